// File: rtl/ahb_master_req_gen.sv
// Per-master AHB request front end: decodes the slave select, holds a one-hot
// request for the whole burst, stalls the master until granted, and answers unmapped addresses with ERROR.
module ahb_master_req_gen #(
    parameter int SLAVE_NUM  = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int SEL_LSB    = 28,
    parameter int SEL_BITS   = 2
) (
    input  logic                  hclk,
    input  logic                  hreset_n,
    input  logic [1:0]            htrans,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [2:0]            hburst,
    input  logic [SLAVE_NUM-1:0]  hgrant,
    output logic [SLAVE_NUM-1:0]  hreq,
    output logic                  hready,
    output logic                  hresp_err,
    output logic                  hlast_beat
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    localparam logic [2:0] BU_SINGLE = 3'd0;
    localparam logic [2:0] BU_INCR   = 3'd1;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_ERR1, S_ERR2} state_t;

    state_t                 state_q, state_d;
    logic [SEL_BITS-1:0]    sel_q, sel_d;
    logic [2:0]             burst_q, burst_d;
    logic [3:0]             lim_q, lim_d;
    logic [3:0]             count_q, count_d;
    logic [SLAVE_NUM-1:0]   hreq_q, hreq_d;
    logic [SEL_BITS-1:0]    idx;
    logic                   mapped;
    logic                   grant_sel;
    logic                   addr_unused;

    // Beat limit stored as limit-1 so the final beat is a direct compare with count.
    function automatic logic [3:0] lim_m1(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: lim_m1 = 4'd3;
            3'd4, 3'd5: lim_m1 = 4'd7;
            3'd6, 3'd7: lim_m1 = 4'd15;
            default:    lim_m1 = 4'd0;
        endcase
    endfunction

    assign idx         = haddr[SEL_LSB +: SEL_BITS];
    assign mapped      = int'(idx) < SLAVE_NUM;
    assign addr_unused = ^haddr;
    assign hreq        = hreq_q;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        burst_d    = burst_q;
        lim_d      = lim_q;
        count_d    = count_q;
        hready     = 1'b1;
        hresp_err  = 1'b0;
        hlast_beat = 1'b0;
        grant_sel  = 1'b0;
        hreq_d     = '0;

        for (int i = 0; i < SLAVE_NUM; i++) begin
            if (sel_q == SEL_BITS'(i)) grant_sel = hgrant[i];
        end

        case (state_q)
            S_IDLE: begin
                if (htrans == TR_NONSEQ) begin
                    hready  = 1'b0;
                    sel_d   = idx;
                    burst_d = hburst;
                    lim_d   = lim_m1(hburst);
                    count_d = 4'd0;
                    state_d = mapped ? S_REQ : S_ERR1;
                end
            end
            S_REQ, S_XFER: begin
                // An undefined-length burst ends as soon as the master stops issuing SEQ/BUSY.
                if (state_q == S_XFER && burst_q == BU_INCR &&
                    (htrans == TR_IDLE || htrans == TR_NONSEQ)) begin
                    hready  = 1'b0;
                    state_d = S_IDLE;
                end else if (state_q == S_XFER && htrans == TR_BUSY) begin
                    hready = 1'b1;
                end else begin
                    hready = grant_sel;
                    if (grant_sel) begin
                        count_d = (count_q == 4'hF) ? count_q : count_q + 4'd1;
                        state_d = S_XFER;
                        if (burst_q == BU_SINGLE ||
                            (burst_q != BU_INCR && count_q == lim_q)) begin
                            hlast_beat = 1'b1;
                            state_d    = S_IDLE;
                        end
                    end
                end
            end
            S_ERR1: begin
                hready    = 1'b0;
                hresp_err = 1'b1;
                state_d   = S_ERR2;
            end
            S_ERR2: begin
                hresp_err = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_REQ || state_d == S_XFER) begin
            for (int i = 0; i < SLAVE_NUM; i++) begin
                hreq_d[i] = (sel_d == SEL_BITS'(i));
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            burst_q <= BU_SINGLE;
            lim_q   <= 4'd0;
            count_q <= 4'd0;
            hreq_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            burst_q <= burst_d;
            lim_q   <= lim_d;
            count_q <= count_d;
            hreq_q  <= hreq_d;
        end
    end

endmodule

// File: doc/ahb_master_req_gen.md
Name: ahb_master_req_gen

Overview:
Per-master request front end. It sits upstream of the per-slave arbiters, one instance per AHB master. It decodes the master's address into a one-hot request toward the slave arbiters and holds that request for the whole burst, counting granted beats against the burst length. It stalls the master via hready until the addressed arbiter grants each beat, and generates a two-cycle ERROR response for unmapped addresses.

Parameters:
SLAVE_NUM, 3, number of slaves/arbiters this master can request (1..2^SEL_BITS)
ADDR_WIDTH, 32, address width
SEL_LSB, 28, lowest address bit of the slave-select field
SEL_BITS, 2, width of the slave-select field

Ports:
hclk  input  1  clock
hreset_n  input  1  synchronous active-low reset
htrans  input  2  master transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
haddr  input  ADDR_WIDTH  master address
hburst  input  hburst_type(3)  SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7
hgrant  input  SLAVE_NUM  this master's grant bit from each slave arbiter (already qualified with ~hwait)
hreq  output  SLAVE_NUM  one-hot request to slave arbiters, registered
hready  output  1  to master: 1 = beat completed / no stall
hresp_err  output  1  to master: ERROR response
hlast_beat  output  1  pulse on acceptance of the final beat of a burst

Behaviour:
- Reset: hreset_n sampled low at a hclk edge puts the block in IDLE. Reset state: sel_q=0, burst_q=SINGLE, count=0, hreq=0, hresp_err=0, hlast_beat=0, hready=1 (comb, IDLE with htrans!=NONSEQ). Reset mid-burst drops hreq on the next edge, with no pending-beat completion.
- Decode: idx = haddr[SEL_LSB +: SEL_BITS]. idx >= SLAVE_NUM is unmapped.
- Beat limit from hburst: SINGLE=1; WRAP4/INCR4=4; WRAP8/INCR8=8; WRAP16/INCR16=16; INCR has no limit.
- FSM states: IDLE, REQ, XFER, ERR1, ERR2.
- IDLE:
  - hready=1 unless htrans==NONSEQ, in which case hready=0.
  - On NONSEQ, latch idx, hburst and limit, and clear count.
  - Mapped idx: go to REQ and set hreq[idx]=1 at the same edge.
  - Unmapped idx: go to ERR1.
  - IDLE/BUSY/SEQ: stay in IDLE. SEQ in IDLE is ignored.
- REQ/XFER:
  - hreq[sel_q]=1 held, all other hreq bits 0.
  - hready = hgrant[sel_q]. A beat is accepted when hgrant[sel_q]=1; count increments on each accepted beat (4-bit, saturates at 15).
  - REQ goes to XFER on the first accepted beat. SINGLE, or any counted burst whose accepted beat has count==limit-1: hlast_beat=1 that cycle, go to IDLE, hreq drops next cycle.
  - XFER with htrans==BUSY: hready=1, no count, hreq held, state unchanged; BUSY overrides hgrant.
  - INCR termination: in XFER, htrans==IDLE or NONSEQ ends the burst. Go to IDLE, clear hreq, hlast_beat=0, hready=0 that cycle. A NONSEQ is then re-evaluated from IDLE on the following cycle; there is no back-to-back chaining.
  - Counted bursts ignore htrans IDLE/NONSEQ until the limit is reached.
  - hgrant bits other than sel_q are ignored.
- ERR1: hresp_err=1, hready=0, hreq=0, then go to ERR2.
- ERR2: hresp_err=1, hready=1, then go to IDLE.
- hreq is one-hot or zero at all times. hlast_beat is never 1 outside REQ/XFER.

Test Plan:
- Reset, then NONSEQ SINGLE haddr=0x1000_0000 (idx 1); hgrant[1] rises 2 cycles after hreq[1] -> hreq=3'b010 from cycle+1; hready=0 for 3 cycles then 1 with hlast_beat=1; hreq=0 next cycle.
- INCR4 to idx 2 (haddr=0x2000_0000), hgrant[2] toggling 1,0,1,1,1 -> count 0→1→1→2→3→4; hlast_beat on the 4th grant; hreq[2] held for the whole burst; hgrant[0]=1 throughout has no effect.
- NONSEQ haddr=0x3000_0000 (idx 3 ≥ SLAVE_NUM) -> hreq stays 0; hready/hresp_err = 0/0, 0/1, 1/1, then 1/0 in IDLE.
- INCR8 with htrans=BUSY on beat 3 for 2 cycles while hgrant=1 -> hready=1, count frozen at 3, burst completes after 8 counted beats.
- INCR to idx 0 with 5 granted beats, then htrans=IDLE -> hreq=0 next cycle, hlast_beat never asserted, FSM in IDLE with hready=1.
- hreset_n low for one edge mid-INCR16 at count=6 -> next cycle hreq=0, count=0, hready=1; a subsequent NONSEQ restarts cleanly.
